ttt_game_ctrl: RTL and testbench
================================

Name: ttt_game_ctrl

Overview:
Tic-tac-toe game engine between keypad_scan and dot_display. Consumes the 4-bit key code from keypad_scan, debounces it, and edge-qualifies it so one press gives one event. It applies moves to the 18-bit board, alternates turns, and detects win or draw. Its board output drives dot_display directly, and its status outputs feed the 7-segment game-state logic.

Parameters:
DEB_CYCLES, 4, consecutive cycles key_data must hold the same nonzero code before the press is accepted (minimum 1).
CNT_W, 16, width of the debounce counter; must hold DEB_CYCLES.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
key_data  input  4  key code: 0 = no key, 1..9 = cells, 10 = '*', 11 = '0', 12 = '#', 13..15 = ignored
board  output  18  cell k (1..9, row-major, 1 = top-left) at board[2k-1:2k-2]; 00 empty, 01 X, 10 O
turn_o  output  1  0 = X to move, 1 = O to move
game_over  output  1  high in OVER state
winner  output  2  00 none, 01 X, 10 O, 11 draw
win_line  output  9  bit k-1 set for each cell on a completed line
move_count  output  4  number of marks placed (0..9)
illegal  output  1  one-cycle pulse on a rejected move

Behaviour:
Clock and reset:
- Single clock, all state on posedge clk.
- rst is synchronous, active-high, and overrides everything, including mid-debounce and the CHECK state.
- Reset values: board = 0, turn_o = 0, game_over = 0, winner = 0, win_line = 0, move_count = 0, illegal = 0, FSM = PLAY, debounce armed = 0, debounce counter = 0.

Debounce and press qualification:
- The armed flag sets once key_data == 0 has been sampled. Out of reset, no press is accepted until a release has been seen.
- While armed, a nonzero code increments the counter while it equals the previous cycle's code; any change of code restarts the count.
- When the count reaches DEB_CYCLES, one press event fires in that cycle for that code and armed clears.
- Holding a key longer never repeats the event. Codes 13..15 clear armed and fire no event.

FSM states: PLAY, CHECK, OVER.
- PLAY, event 1..9 on an empty cell:
  - Write the mark (01 if turn_o = 0, else 10) and increment move_count, both visible the next cycle.
  - Go to CHECK.
- PLAY, event 1..9 on an occupied cell: pulse illegal for 1 cycle; no other change.
- PLAY, events 10 and 11: ignored.
- CHECK (exactly 1 cycle): evaluate all 8 lines (3 rows, 3 columns, 2 diagonals) for the mark just placed.
  - Any line complete: winner = mover, win_line = OR of all completed lines, game_over = 1, go to OVER. turn_o is not toggled.
  - Else, if move_count == 9: winner = 11, win_line = 0, game_over = 1, go to OVER.
  - Else: toggle turn_o and return to PLAY.
- OVER: cell keys are ignored with no illegal pulse; board stays frozen.
- Event 12 ('#') in any state, including CHECK: next cycle board = 0, move_count = 0, turn_o = 0, winner = 0, win_line = 0, game_over = 0, FSM = PLAY. The debounce armed logic is unaffected.

Latency:
- Press accepted at cycle t: board and move_count update at t+1.
- winner, game_over, win_line and turn_o update at t+2.
- A press event arriving while in CHECK is dropped. This is unreachable when DEB_CYCLES >= 2 plus the mandatory release.
- A win on the 9th move reports the winner, not a draw.

Test Plan:
- Reset then press 5 (key_data = 5 for DEB_CYCLES cycles, then 0) -> board[9:8] = 01, all other board bits 0, move_count = 1, turn_o = 1 two cycles after acceptance.
- Hold key 3 for 50 cycles -> exactly one move; board[5:4] = 01, move_count = 1. Pressing 3 again after release -> illegal pulses 1 cycle, board unchanged, turn_o = 1.
- Glitch: key_data 7 for DEB_CYCLES-1 cycles, then 0 -> no event, board = 0.
- Sequence 1,4,2,5,3 -> after move 5: winner = 01, game_over = 1, win_line = 9'b000000111, turn_o = 0. A following press of 9 is ignored and illegal stays 0.
- Sequence 1,2,3,5,4,6,8,7,9 -> winner = 11, move_count = 9, win_line = 0. Then press '#' -> board = 0, winner = 0, game_over = 0, turn_o = 0.
- Assert rst during the CHECK cycle of a winning move -> next cycle all outputs at reset values. A press without a prior release after reset is not accepted.

Source files
------------

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe engine: debounces keypad codes, applies moves, detects win/draw.
// Latency: accepted press -> board/move_count at t+1, winner/game_over/win_line/turn_o at t+2.
// Backpressure: none; presses in CHECK are dropped, cell keys in OVER are ignored.
//
// Ports:
//   clk, rst            - system clock, synchronous active-high reset
//   key_data[3:0]       - keypad code (0 none, 1..9 cells, 10 '*', 11 '0', 12 '#', 13..15 ignored)
//   board[17:0]         - cell k at [2k-1:2k-2]: 00 empty, 01 X, 10 O
//   turn_o              - 0 X to move, 1 O to move
//   game_over           - high in OVER
//   winner[1:0]         - 00 none, 01 X, 10 O, 11 draw
//   win_line[8:0]       - bit k-1 set for each cell on a completed line
//   move_count[3:0]     - marks placed
//   illegal             - one-cycle pulse on a move to an occupied cell
module ttt_game_ctrl #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  key_data,
    output logic [17:0] board,
    output logic        turn_o,
    output logic        game_over,
    output logic [1:0]  winner,
    output logic [8:0]  win_line,
    output logic [3:0]  move_count,
    output logic        illegal
);

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        CHECK = 2'd1,
        OVER  = 2'd2
    } state_t;

    // Cell masks of the 8 lines: rows, columns, diagonals (bit i = cell i+1).
    localparam logic [8:0] LINES [8] = '{
        9'b000_000_111, 9'b000_111_000, 9'b111_000_000,
        9'b001_001_001, 9'b010_010_010, 9'b100_100_100,
        9'b100_010_001, 9'b001_010_100
    };

    state_t           state;
    logic             armed;
    logic [CNT_W-1:0] deb_cnt;
    logic [3:0]       prev_key;

    logic [CNT_W-1:0] cnt_next;
    logic             key_ok;
    logic             press_vld;
    logic             is_cell;
    logic [3:0]       cell_idx;
    logic [4:0]       cell_bit;
    logic             cell_empty;
    logic [1:0]       mover_mark;
    logic [8:0]       mine;
    logic [8:0]       win_mask;

    // ------------------------------------------------------------------
    // Debounce: count consecutive cycles of the same nonzero code. The
    // first cycle of a new code counts as 1, so the event fires on the
    // DEB_CYCLES-th cycle the code is held.
    // ------------------------------------------------------------------
    always_comb begin
        cnt_next  = (key_data == prev_key) ? deb_cnt + 1'b1 : CNT_W'(1);
        key_ok    = (key_data >= 4'd1) && (key_data <= 4'd12);
        press_vld = armed && key_ok && (cnt_next == CNT_W'(DEB_CYCLES));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            armed    <= 1'b0;
            deb_cnt  <= '0;
            prev_key <= 4'd0;
        end else begin
            prev_key <= key_data;
            if (key_data == 4'd0) begin
                armed   <= 1'b1;
                deb_cnt <= '0;
            end else if (!armed) begin
                deb_cnt <= '0;
            end else if (!key_ok || press_vld) begin
                // Codes 13..15 and an accepted press both need a release
                // before the next event can fire.
                armed   <= 1'b0;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= cnt_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Move decode and line evaluation
    // ------------------------------------------------------------------
    always_comb begin
        is_cell    = (key_data >= 4'd1) && (key_data <= 4'd9);
        cell_idx   = key_data - 4'd1;
        cell_bit   = {cell_idx, 1'b0};
        cell_empty = (board[cell_bit +: 2] == 2'b00);
        mover_mark = turn_o ? 2'b10 : 2'b01;
        for (int i = 0; i < 9; i++) begin
            mine[i] = (board[2*i +: 2] == mover_mark);
        end
        win_mask = '0;
        for (int l = 0; l < 8; l++) begin
            if ((mine & LINES[l]) == LINES[l]) begin
                win_mask = win_mask | LINES[l];
            end
        end
    end

    // ------------------------------------------------------------------
    // Game FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= PLAY;
            board      <= '0;
            turn_o     <= 1'b0;
            game_over  <= 1'b0;
            winner     <= 2'b00;
            win_line   <= '0;
            move_count <= 4'd0;
            illegal    <= 1'b0;
        end else begin
            illegal <= 1'b0;
            if (press_vld && (key_data == 4'd12)) begin
                // '#' restarts the game from any state.
                state      <= PLAY;
                board      <= '0;
                turn_o     <= 1'b0;
                game_over  <= 1'b0;
                winner     <= 2'b00;
                win_line   <= '0;
                move_count <= 4'd0;
            end else begin
                case (state)
                    PLAY: begin
                        if (press_vld && is_cell) begin
                            if (cell_empty) begin
                                board[cell_bit +: 2] <= mover_mark;
                                move_count           <= move_count + 4'd1;
                                state                <= CHECK;
                            end else begin
                                illegal <= 1'b1;
                            end
                        end
                    end
                    CHECK: begin
                        // Win takes precedence over draw on the 9th move.
                        if (win_mask != 9'd0) begin
                            winner    <= mover_mark;
                            win_line  <= win_mask;
                            game_over <= 1'b1;
                            state     <= OVER;
                        end else if (move_count == 4'd9) begin
                            winner    <= 2'b11;
                            win_line  <= '0;
                            game_over <= 1'b1;
                            state     <= OVER;
                        end else begin
                            turn_o <= ~turn_o;
                            state  <= PLAY;
                        end
                    end
                    OVER: begin
                        state <= OVER;
                    end
                    default: begin
                        state <= PLAY;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed bench for ttt_game_ctrl with DEB_CYCLES = 4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Each comparison is an immediate assertion that counts failures.
module tb_ttt_game_ctrl;

    localparam int DEB = 4;

    logic        clk;
    logic        rst;
    logic [3:0]  key_data;
    logic [17:0] board;
    logic        turn_o;
    logic        game_over;
    logic [1:0]  winner;
    logic [8:0]  win_line;
    logic [3:0]  move_count;
    logic        illegal;

    int n_cmp;
    int n_bad;

    logic ill1, ill2;

    ttt_game_ctrl #(.DEB_CYCLES(DEB), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_data   (key_data),
        .board      (board),
        .turn_o     (turn_o),
        .game_over  (game_over),
        .winner     (winner),
        .win_line   (win_line),
        .move_count (move_count),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold a code for exactly DEB cycles then release. ill_a is illegal
    // right after the accepting edge, ill_b one cycle later.
    task automatic press(input logic [3:0] code, output logic ill_a, output logic ill_b);
        key_data = code;
        tick(DEB);
        ill_a = illegal;
        key_data = 4'd0;
        tick(1);
        ill_b = illegal;
        tick(2);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".board"},      32'(board),      32'h0);
        chk({tag, ".turn"},       32'(turn_o),     32'h0);
        chk({tag, ".game_over"},  32'(game_over),  32'h0);
        chk({tag, ".winner"},     32'(winner),     32'h0);
        chk({tag, ".win_line"},   32'(win_line),   32'h0);
        chk({tag, ".move_count"}, 32'(move_count), 32'h0);
        chk({tag, ".illegal"},    32'(illegal),    32'h0);
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rst      = 1'b1;
        key_data = 4'd0;
        tick(3);
        chk_reset_vals("reset");
        rst = 1'b0;
        tick(2);

        // Single press of the centre cell.
        press(4'd5, ill1, ill2);
        chk("p5.board",      32'(board),      32'h00100);
        chk("p5.move_count", 32'(move_count), 32'd1);
        chk("p5.turn",       32'(turn_o),     32'd1);
        press(4'd12, ill1, ill2);
        chk("hash1.board", 32'(board),  32'h0);
        chk("hash1.turn",  32'(turn_o), 32'd0);

        // Long hold gives one move only.
        key_data = 4'd3;
        tick(50);
        key_data = 4'd0;
        tick(3);
        chk("hold.board",      32'(board),      32'h00010);
        chk("hold.move_count", 32'(move_count), 32'd1);
        press(4'd3, ill1, ill2);
        chk("ill.pulse",      32'(ill1),       32'd1);
        chk("ill.cleared",    32'(ill2),       32'd0);
        chk("ill.board",      32'(board),      32'h00010);
        chk("ill.turn",       32'(turn_o),     32'd1);
        chk("ill.move_count", 32'(move_count), 32'd1);
        press(4'd12, ill1, ill2);

        // Glitch shorter than the debounce window.
        key_data = 4'd7;
        tick(DEB - 1);
        key_data = 4'd0;
        tick(4);
        chk("glitch.board",      32'(board),      32'h0);
        chk("glitch.move_count", 32'(move_count), 32'd0);

        // X wins on the top row.
        press(4'd1, ill1, ill2);
        press(4'd4, ill1, ill2);
        press(4'd2, ill1, ill2);
        press(4'd5, ill1, ill2);
        press(4'd3, ill1, ill2);
        chk("xwin.board",     32'(board),     32'h00295);
        chk("xwin.winner",    32'(winner),    32'd1);
        chk("xwin.game_over", 32'(game_over), 32'd1);
        chk("xwin.win_line",  32'(win_line),  32'h007);
        chk("xwin.turn",      32'(turn_o),    32'd0);
        press(4'd9, ill1, ill2);
        chk("over.illegal", 32'(ill1),  32'd0);
        chk("over.board",   32'(board), 32'h00295);
        press(4'd12, ill1, ill2);

        // Draw.
        press(4'd1, ill1, ill2);
        press(4'd2, ill1, ill2);
        press(4'd3, ill1, ill2);
        press(4'd5, ill1, ill2);
        press(4'd4, ill1, ill2);
        press(4'd6, ill1, ill2);
        press(4'd8, ill1, ill2);
        press(4'd7, ill1, ill2);
        press(4'd9, ill1, ill2);
        chk("draw.board",      32'(board),      32'h16A59);
        chk("draw.winner",     32'(winner),     32'd3);
        chk("draw.move_count", 32'(move_count), 32'd9);
        chk("draw.win_line",   32'(win_line),   32'h0);
        chk("draw.game_over",  32'(game_over),  32'd1);
        press(4'd12, ill1, ill2);
        chk("hash2.board",     32'(board),     32'h0);
        chk("hash2.winner",    32'(winner),    32'd0);
        chk("hash2.game_over", 32'(game_over), 32'd0);
        chk("hash2.turn",      32'(turn_o),    32'd0);

        // Reset during CHECK of a winning move.
        press(4'd1, ill1, ill2);
        press(4'd4, ill1, ill2);
        press(4'd2, ill1, ill2);
        press(4'd5, ill1, ill2);
        key_data = 4'd3;
        tick(DEB);
        chk("pre_rst.board", 32'(board), 32'h00295);
        rst = 1'b1;
        tick(1);
        chk_reset_vals("rst_check");
        rst = 1'b0;
        tick(10);
        chk("noarm.board",      32'(board),      32'h0);
        chk("noarm.move_count", 32'(move_count), 32'd0);
        key_data = 4'd0;
        tick(2);
        press(4'd3, ill1, ill2);
        chk("rearm.board", 32'(board), 32'h00010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
